// File: rtl/plab5_mcore_mem_arbiter_rr.sv
// N-port round-robin memory arbiter; an in-order FIFO of granted port indices routes responses.
// Optional macro PLAB5_MEM_ARB_DOMAIN_CHECK_EN: track request domains and flag mismatching responses.
module plab5_mcore_mem_arbiter_rr #(
    parameter int unsigned p_num_ports       = 2,
    parameter int unsigned p_opaque_nbits    = 8,
    parameter int unsigned p_addr_nbits      = 32,
    parameter int unsigned p_data_nbits      = 32,
    parameter int unsigned p_max_outstanding = 4,
    localparam int unsigned LenW = $clog2(p_data_nbits / 8),
    localparam int unsigned Rqc  = 3 + p_opaque_nbits + p_addr_nbits + LenW,
    localparam int unsigned Rsc  = 3 + p_opaque_nbits + LenW
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [p_num_ports-1:0]              reqs_val_i,
    output logic [p_num_ports-1:0]              reqs_rdy_o,
    input  logic [p_num_ports*Rqc-1:0]          reqs_control_i,
    input  logic [p_num_ports*p_data_nbits-1:0] reqs_data_i,
    input  logic [p_num_ports-1:0]              reqs_domain_i,
    output logic                                req_val_o,
    input  logic                                req_rdy_i,
    output logic [Rqc-1:0]                      req_control_o,
    output logic [p_data_nbits-1:0]             req_data_o,
    output logic                                req_domain_o,
    input  logic                                resp_val_i,
    output logic                                resp_rdy_o,
    input  logic [Rsc-1:0]                      resp_control_i,
    input  logic [p_data_nbits-1:0]             resp_data_i,
    input  logic                                resp_domain_i,
    output logic [p_num_ports-1:0]              resps_val_o,
    input  logic [p_num_ports-1:0]              resps_rdy_i,
    output logic [p_num_ports*Rsc-1:0]          resps_control_o,
    output logic [p_num_ports*p_data_nbits-1:0] resps_data_o,
    output logic [p_num_ports-1:0]              resps_domain_o,
    output logic                                domain_err_o
);

    localparam int unsigned IdxW = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
    localparam int unsigned PtrW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam int unsigned CntW = $clog2(p_max_outstanding + 1);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] fifo_idx_q [p_max_outstanding];

    logic [IdxW-1:0]        grant_idx, scan_idx, head_idx;
    logic [p_num_ports-1:0] grant;
    logic                   any_val, fifo_full, fifo_empty, req_fire, resp_fire;
    logic [p_data_nbits-1:0] out_data;
    logic                    out_domain;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == p_max_outstanding - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign any_val    = |reqs_val_i;
    assign fifo_full  = (count_q == CntW'(p_max_outstanding));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_idx_q[rd_ptr_q];

    // Scan downward so the nearest valid port at or after rr_ptr wins.
    always_comb begin
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = p_num_ports - 1; k >= 0; k--) begin
            scan_idx = IdxW'((32'(rr_ptr_q) + unsigned'(k)) % p_num_ports);
            if (reqs_val_i[scan_idx]) grant_idx = scan_idx;
        end
        for (int i = 0; i < p_num_ports; i++) begin
            grant[i] = any_val && (grant_idx == IdxW'(i));
        end
    end

    always_comb begin
        req_val_o     = !reset_i && any_val && !fifo_full;
        reqs_rdy_o    = (!reset_i && req_rdy_i && !fifo_full) ? grant : '0;
        req_control_o = '0;
        req_data_o    = '0;
        req_domain_o  = 1'b0;
        if (any_val) begin
            req_control_o = reqs_control_i[grant_idx*Rqc +: Rqc];
            req_data_o    = reqs_data_i[grant_idx*p_data_nbits +: p_data_nbits];
            req_domain_o  = reqs_domain_i[grant_idx];
        end
    end

    assign req_fire   = req_val_o && req_rdy_i;
    assign resp_rdy_o = !reset_i && !fifo_empty && resps_rdy_i[head_idx];
    assign resp_fire  = resp_val_i && resp_rdy_o;

    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            resps_val_o[i] = !reset_i && resp_val_i && !fifo_empty && (head_idx == IdxW'(i));
        end
    end

    assign resps_control_o = {p_num_ports{resp_control_i}};
    assign resps_data_o    = {p_num_ports{out_data}};
    assign resps_domain_o  = {p_num_ports{out_domain}};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (req_fire) begin
            rr_ptr_d = (32'(grant_idx) == p_num_ports - 1) ? '0 : grant_idx + IdxW'(1);
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (resp_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (req_fire && !resp_fire) count_d = count_q + CntW'(1);
        else if (!req_fire && resp_fire) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) fifo_idx_q[wr_ptr_q] <= grant_idx;
    end

`ifdef PLAB5_MEM_ARB_DOMAIN_CHECK_EN
    logic fifo_dom_q [p_max_outstanding];
    logic head_dom, dom_mismatch, domain_err_q, domain_err_d;

    assign head_dom     = fifo_dom_q[rd_ptr_q];
    assign dom_mismatch = resp_val_i && !fifo_empty && (resp_domain_i != head_dom);
    // A mismatching response is still delivered and popped, but its payload is scrubbed.
    assign out_data     = dom_mismatch ? '0 : resp_data_i;
    assign out_domain   = dom_mismatch ? head_dom : resp_domain_i;
    assign domain_err_d = domain_err_q || (resp_fire && dom_mismatch);
    assign domain_err_o = domain_err_q;

    always_ff @(posedge clk_i) begin
        if (req_fire) fifo_dom_q[wr_ptr_q] <= req_domain_o;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) domain_err_q <= 1'b0;
        else         domain_err_q <= domain_err_d;
    end
`else
    assign out_data     = resp_data_i;
    assign out_domain   = resp_domain_i;
    assign domain_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_arbiter_rr.sv
// Scoreboard bench for plab5_mcore_mem_arbiter_rr: directed stimulus, queue-based monitors.
`timescale 1ns/1ps
module tb_plab5_mcore_mem_arbiter_rr;

    localparam int N   = 4;
    localparam int M   = 4;
    localparam int O   = 8;
    localparam int A   = 32;
    localparam int D   = 32;
    localparam int RQC = 3 + O + A + 2;
    localparam int RSC = 3 + O + 2;
`ifdef PLAB5_MEM_ARB_DOMAIN_CHECK_EN
    localparam bit DCHK = 1'b1;
`else
    localparam bit DCHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     reqs_val, reqs_rdy, reqs_domain;
    logic [N*RQC-1:0] reqs_control;
    logic [N*D-1:0]   reqs_data;
    logic             req_val, req_rdy, req_domain;
    logic [RQC-1:0]   req_control;
    logic [D-1:0]     req_data;
    logic             resp_val, resp_rdy, resp_domain;
    logic [RSC-1:0]   resp_control;
    logic [D-1:0]     resp_data;
    logic [N-1:0]     resps_val, resps_rdy, resps_domain;
    logic [N*RSC-1:0] resps_control;
    logic [N*D-1:0]   resps_data;
    logic             domain_err;

    always #5 clk = ~clk;

    plab5_mcore_mem_arbiter_rr #(
        .p_num_ports      (N),
        .p_opaque_nbits   (O),
        .p_addr_nbits     (A),
        .p_data_nbits     (D),
        .p_max_outstanding(M)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .reqs_val_i     (reqs_val),
        .reqs_rdy_o     (reqs_rdy),
        .reqs_control_i (reqs_control),
        .reqs_data_i    (reqs_data),
        .reqs_domain_i  (reqs_domain),
        .req_val_o      (req_val),
        .req_rdy_i      (req_rdy),
        .req_control_o  (req_control),
        .req_data_o     (req_data),
        .req_domain_o   (req_domain),
        .resp_val_i     (resp_val),
        .resp_rdy_o     (resp_rdy),
        .resp_control_i (resp_control),
        .resp_data_i    (resp_data),
        .resp_domain_i  (resp_domain),
        .resps_val_o    (resps_val),
        .resps_rdy_i    (resps_rdy),
        .resps_control_o(resps_control),
        .resps_data_o   (resps_data),
        .resps_domain_o (resps_domain),
        .domain_err_o   (domain_err)
    );

    typedef struct {
        int             port;
        logic [RQC-1:0] ctl;
        logic [D-1:0]   data;
        logic           dom;
    } req_t;
    typedef struct {
        int             port;
        logic [RSC-1:0] ctl;
        logic [D-1:0]   data;
        logic           dom;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   tests = 0;
    int   fails = 0;

    // Memory model state
    logic [D-1:0]   mq_data[$];
    logic           mq_dom[$];
    logic [RSC-1:0] mq_ctl[$];
    bit             resp_fire_seen = 1'b0;
    int             budget = 0;
    bit             spurious = 1'b0;
    bit             mem_bad = 1'b0;

    int           tag = 0;
    logic [N-1:0] dom_pat = 4'b1010;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [D-1:0] f_data(input int i, input int t);
        return 32'hD000_C0DE ^ (32'(i) << 24) ^ (32'(t & 255) << 16);
    endfunction

    function automatic logic [RQC-1:0] f_ctl(input int i, input int t);
        return RQC'((64'(i) << 40) ^ (64'(t) << 3) ^ 64'h0123_4567_89AB);
    endfunction

    // One stimulus cycle; exp_port >= 0 means this cycle's request is expected to be granted there.
    task automatic drive(input logic [N-1:0] val, input int exp_port, input bit bad = 1'b0);
        logic [RQC-1:0] c;
        rsp_t r;
        @(posedge clk);
        #1;
        tag++;
        reqs_val = val;
        for (int i = 0; i < N; i++) begin
            reqs_control[i*RQC +: RQC] = f_ctl(i, tag);
            reqs_data[i*D +: D]        = f_data(i, tag);
            reqs_domain[i]             = dom_pat[i];
        end
        if (exp_port >= 0) begin
            c = f_ctl(exp_port, tag);
            exp_req.push_back('{exp_port, c, f_data(exp_port, tag), dom_pat[exp_port]});
            r.port = exp_port;
            r.ctl  = c[RSC-1:0];
            if (bad) begin
                r.data = DCHK ? 32'h0 : 32'hDEAD_BEEF;
                r.dom  = DCHK ? dom_pat[exp_port] : ~dom_pat[exp_port];
            end else begin
                r.data = ~f_data(exp_port, tag);
                r.dom  = dom_pat[exp_port];
            end
            exp_rsp.push_back(r);
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((exp_req.size() + exp_rsp.size()) != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending_after_drain"}, 64'(exp_req.size() + exp_rsp.size()), 64'd0);
    endtask

    // Request monitor
    always @(negedge clk) begin
        req_t e;
        if (!rst && req_val && req_rdy) begin
            if (exp_req.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL req_unexpected: got reqs_rdy 0x%0h, expected no request", reqs_rdy);
            end else begin
                e = exp_req.pop_front();
                chk("req_grant", 64'(reqs_rdy), 64'(1) << e.port);
                chk("req_control", 64'(req_control), 64'(e.ctl));
                chk("req_data", 64'(req_data), 64'(e.data));
                chk("req_domain", 64'(req_domain), 64'(e.dom));
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (resps_val[i] && resps_rdy[i]) begin
                    if (exp_rsp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL resp_unexpected: got response on port %0d, expected none", i);
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("resp_port", 64'(i), 64'(e.port));
                        chk("resp_control", 64'(resps_control[i*RSC +: RSC]), 64'(e.ctl));
                        chk("resp_data", 64'(resps_data[i*D +: D]), 64'(e.data));
                        chk("resp_domain", 64'(resps_domain[i]), 64'(e.dom));
                    end
                end
            end
        end
    end

    // Memory model: record handshakes away from the edge, update the response one step after it.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_val && req_rdy) begin
                mq_data.push_back(req_data);
                mq_dom.push_back(req_domain);
                mq_ctl.push_back(req_control[RSC-1:0]);
            end
            if (resp_val && resp_rdy) resp_fire_seen = 1'b1;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            mq_data.delete();
            mq_dom.delete();
            mq_ctl.delete();
            resp_fire_seen = 1'b0;
            resp_val = 1'b0;
        end else begin
            if (resp_fire_seen) begin
                if (mq_data.size() > 0) begin
                    void'(mq_data.pop_front());
                    void'(mq_dom.pop_front());
                    void'(mq_ctl.pop_front());
                end
                budget--;
                resp_fire_seen = 1'b0;
            end
            if (mq_data.size() > 0 && budget > 0) begin
                resp_val     = 1'b1;
                resp_control = mq_ctl[0];
                resp_data    = mem_bad ? 32'hDEAD_BEEF : ~mq_data[0];
                resp_domain  = mem_bad ? ~mq_dom[0] : mq_dom[0];
            end else if (spurious) begin
                resp_val     = 1'b1;
                resp_control = '0;
                resp_data    = 32'h5A5A_5A5A;
                resp_domain  = 1'b0;
            end else begin
                resp_val = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reqs_val     = '1;
        reqs_control = '0;
        reqs_data    = '0;
        reqs_domain  = '0;
        req_rdy      = 1'b1;
        resp_val     = 1'b0;
        resp_control = '0;
        resp_data    = '0;
        resp_domain  = 1'b0;
        resps_rdy    = '1;

        // Reset forces every val/rdy output low even with live inputs
        repeat (2) @(negedge clk);
        chk("rst_req_val", 64'(req_val), 64'd0);
        chk("rst_reqs_rdy", 64'(reqs_rdy), 64'd0);
        chk("rst_resp_rdy", 64'(resp_rdy), 64'd0);
        chk("rst_resps_val", 64'(resps_val), 64'd0);
        chk("rst_domain_err", 64'(domain_err), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        reqs_val = '0;
        budget   = 1000;

        // Two contenders alternate 0,1,0,1 starting from rr_ptr=0
        drive(4'b0011, 0);
        drive(4'b0011, 1);
        drive(4'b0011, 0);
        drive(4'b0011, 1);
        drive(4'b0000, -1);
        drain("alternate", 20);

        // Lone port 2 is granted back-to-back; rr_ptr ends at 3
        for (int k = 0; k < 4; k++) drive(4'b0100, 2);
        drive(4'b1111, 3);
        drive(4'b0000, -1);
        drain("lone_port", 20);

        // Fill the tracking FIFO with no responses
        budget = 0;
        for (int k = 0; k < 4; k++) drive(4'b0001, 0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, -1);
            @(negedge clk);
            chk("full_req_val", 64'(req_val), 64'd0);
            chk("full_reqs_rdy", 64'(reqs_rdy), 64'd0);
        end
        drive(4'b0001, -1);
        budget = 1;
        @(negedge clk);
        chk("pop_while_full_req_val", 64'(req_val), 64'd0);
        chk("pop_while_full_resp_rdy", 64'(resp_rdy), 64'd1);
        drive(4'b0001, 0);
        @(negedge clk);
        chk("reopened_req_val", 64'(req_val), 64'd1);
        drive(4'b0001, -1);
        @(negedge clk);
        chk("refilled_req_val", 64'(req_val), 64'd0);

        // Head port not ready: response is held, not popped
        drive(4'b0000, -1);
        resps_rdy = 4'b1110;
        budget    = 1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_resp_rdy", 64'(resp_rdy), 64'd0);
            chk("hold_resps_val", 64'(resps_val), 64'b0001);
        end
        chk("hold_pending", 64'(exp_rsp.size()), 64'd4);
        @(posedge clk);
        #1;
        resps_rdy = '1;
        @(negedge clk);
        chk("release_resp_rdy", 64'(resp_rdy), 64'd1);
        drain("head_hold", 20);

        // Response with nothing outstanding is held off
        @(posedge clk);
        #1;
        spurious = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("empty_resp_rdy", 64'(resp_rdy), 64'd0);
            chk("empty_resps_val", 64'(resps_val), 64'd0);
        end
        @(posedge clk);
        #1;
        spurious = 1'b0;

        // Domain mismatch on a response
        dom_pat = 4'b0010;
        mem_bad = 1'b1;
        drive(4'b0010, 1, 1'b1);
        drive(4'b0000, -1);
        drain("domain_bad", 20);
        mem_bad = 1'b0;
        chk("domain_err_set", 64'(domain_err), 64'(DCHK));
        dom_pat = 4'b1010;
        drive(4'b0100, 2);
        drive(4'b0000, -1);
        drain("domain_good", 20);
        chk("domain_err_sticky", 64'(domain_err), 64'(DCHK));

        // Asynchronous reset with traffic in flight
        budget = 0;
        drive(4'b1000, 3);
        drive(4'b1000, 3);
        @(posedge clk);
        #1;
        reqs_val  = '1;
        req_rdy   = 1'b0;
        resps_rdy = 4'b0111;
        budget    = 1;
        @(negedge clk);
        chk("pre_rst_req_val", 64'(req_val), 64'd1);
        chk("pre_rst_resps_val", 64'(resps_val), 64'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req_val", 64'(req_val), 64'd0);
        chk("async_rst_reqs_rdy", 64'(reqs_rdy), 64'd0);
        chk("async_rst_resp_rdy", 64'(resp_rdy), 64'd0);
        chk("async_rst_resps_val", 64'(resps_val), 64'd0);
        chk("async_rst_domain_err", 64'(domain_err), 64'd0);
        exp_req.delete();
        exp_rsp.delete();
        mq_data.delete();
        mq_dom.delete();
        mq_ctl.delete();
        resp_fire_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_rdy   = 1'b1;
        resps_rdy = '1;
        budget    = 0;
        reqs_val  = '0;

        // After reset rr_ptr is 0 and the FIFO holds exactly M again
        drive(4'b1111, 0);
        for (int k = 0; k < 3; k++) drive(4'b0100, 2);
        drive(4'b0100, -1);
        @(negedge clk);
        chk("post_rst_full_req_val", 64'(req_val), 64'd0);
        drive(4'b0000, -1);
        budget = 1000;
        drain("post_reset", 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/plab5_mcore_mem_arbiter_rr.md
Name: plab5_mcore_mem_arbiter_rr

Overview:
N-port, round-robin, pipelined arbiter between per-core memory request streams and a single main-memory port.
- Multiple requests may be in flight; each issued request's port index is recorded in an in-order tracking FIFO so each response returns to its requester.
- Supersedes the fixed two-port, one-transaction-at-a-time arbiter in the multicore memory path.
- Security domain bit travels with every request and response.

Parameters:
p_num_ports, 2, number of requester ports N (2..8)
p_opaque_nbits, 8, opaque field width o
p_addr_nbits, 32, address width a
p_data_nbits, 32, data width d
p_max_outstanding, 4, tracking FIFO depth M (power of 2, >=1)
rqc, `VC_MEM_REQ_MSG_NBITS(o,a,d)-d, request control width
rsc, `VC_MEM_RESP_MSG_NBITS(o,d)-d, response control width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
reqs_val  in  N  per-port request valid
reqs_rdy  out  N  per-port request ready
reqs_control  in  N*rqc  per-port request control, port i at [i*rqc +: rqc]
reqs_data  in  N*d  per-port request data
reqs_domain  in  N  per-port request domain
req_val / req_rdy  out / in  1 / 1  memory-side request handshake
req_control / req_data / req_domain  out  rqc / d / 1  granted request fields
resp_val / resp_rdy  in / out  1 / 1  memory-side response handshake
resp_control / resp_data / resp_domain  in  rsc / d / 1  response fields
resps_val  out  N  per-port response valid
resps_rdy  in  N  per-port response ready
resps_control / resps_data / resps_domain  out  N*rsc / N*d / N  response fields broadcast to all ports
domain_err  out  1  sticky domain-mismatch flag (see Optional Feature)

Behaviour:
- Handshake: a transfer fires when val && rdy in the same cycle. val never depends on rdy.
- Grant (combinational): first port with reqs_val set, searching from rr_ptr upward modulo N. grant is a one-hot N-bit vector.
- Request path:
  - req_val = |reqs_val && !fifo_full.
  - Request fields mux from the granted port; they are 0 when no grant.
  - reqs_rdy[i] = grant[i] && req_rdy && !fifo_full.
- On request fire:
  - Push the granted index into the tracking FIFO.
  - rr_ptr <= (granted index + 1) mod N.
  - rr_ptr is unchanged when no request fires.
- Response path:
  - Memory returns responses in request order.
  - head = FIFO head index.
  - resps_val[i] = resp_val && !fifo_empty && head==i.
  - resp_rdy = !fifo_empty && resps_rdy[head].
  - Response fields are broadcast unmodified to all ports (except under the feature).
- On response fire: pop the FIFO.
- FIFO is pointer-based with a count of 0..M; pointers wrap modulo M.
- Full (count==M): no request accepted, even if a pop occurs in the same cycle; no bypass.
- Push and pop in the same cycle when not full: count unchanged, both pointers advance.
- Empty with resp_val=1: resp_rdy=0; response held off, not dropped.
- Latency: request forwarded combinationally (0 cycles); response routed combinationally (0 cycles); no internal data registers.
- Reset (asynchronous, immediate):
  - rr_ptr=0, FIFO empty, domain_err=0.
  - While reset is high, every *_val and *_rdy output is forced to 0.
  - Reset mid-operation discards all in-flight tracking; the system resets memory concurrently.

Optional Feature:
PLAB5_MEM_ARB_DOMAIN_CHECK_EN
- Defined:
  - FIFO entries also store req_domain.
  - On a response whose resp_domain differs from the stored domain: the response is still delivered to the head port and popped, but resps_data is forced to 0 and resps_domain is forced to the stored domain.
  - The mismatch sets domain_err (sticky until reset).
- Undefined: no domain storage; domain_err is tied 0.

Test Plan:
- N=2, both ports valid every cycle, req_rdy=1, resp returned one cycle later → grants alternate 0,1,0,1; responses reach ports 0,1,0,1 with matching data.
- N=4, only port 2 valid, four requests → all four granted back-to-back; rr_ptr=3 after each.
- M=4, req_rdy=1, resp_val=0, eight requests → first four accepted; req_val=0 and reqs_rdy=0 from the fifth cycle; one response fire re-opens exactly one slot.
- Empty FIFO, resp_val=1 → resp_rdy=0 and all resps_val=0.
- Head port's resps_rdy=0 for 3 cycles → resp_rdy=0 for those cycles; no pop; the response is delivered on the cycle resps_rdy rises.
- Feature on: request with domain 1, response with domain 0 and data 0xDEADBEEF → port receives data 0 and domain 1; domain_err=1 and stays 1 until reset. Asserting reset mid-stream → count=0 and all val/rdy outputs low immediately.
